// File: rtl/sa_ram_rwsp_param.sv
// sa_ram_rwsp_param
//   Single-port-style RAM with one write port and one two-stage read port.
//   Read path: ra is captured into ra_d on re. The array is read
//   combinationally from ra_d. The result is captured into dout on ore.
//   Out-of-range addresses raise a sticky err flag. Out-of-range writes
//   are dropped. Out-of-range reads return zero with dout_vld=0.
// Ports
//   clk, rstn      : clock, asynchronous active-low reset
//   ra, re         : read address, read-address capture enable
//   ore            : output-register capture enable
//   dout, dout_vld : registered read data, data-came-from-valid-address flag
//   wa, we, di     : write address, write enable, write data
//   err            : sticky out-of-range access flag
//   pwrbus_ram_pd  : power-down bus; bit 0 blocks writes
module sa_ram_rwsp_param #(
  parameter int DEPTH = 61,
  parameter int WIDTH = 65,
  parameter int AW = $clog2(DEPTH),
  parameter bit RDW_NEW = 1'b0,
  parameter bit FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  input  logic             ore,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [WIDTH-1:0] di,
  output logic             err,
  input  logic [31:0]      pwrbus_ram_pd
);

  // With a power-of-two depth every address is legal, so err is tied low.
  localparam bit POW2 = (DEPTH & (DEPTH - 1)) == 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ra_d;
  logic             ra_ok;
  logic             wa_ok, ra_in_ok, wr_en, bypass;
  logic [WIDTH-1:0] mem_q;

  // Only bit 0 of the power bus and none of the compatibility parameter matter.
  logic unused_ok;
  assign unused_ok = ^{pwrbus_ram_pd[31:1], FORCE_CONTENTION_ASSERTION_RESET_ACTIVE};

  assign wa_ok    = 32'(wa) < 32'(DEPTH);
  assign ra_in_ok = 32'(ra) < 32'(DEPTH);
  // rstn gates the write so the array is frozen while reset is held.
  assign wr_en    = we & wa_ok & ~pwrbus_ram_pd[0] & rstn;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wa] <= di;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ra_d  <= '0;
      ra_ok <= 1'b0;
    end else if (re) begin
      ra_d  <= ra;
      ra_ok <= ra_in_ok;
    end
  end

  assign mem_q = ra_ok ? mem[ra_d] : '0;

  // A same-edge write to the word being output may be forwarded.
  // A blocked write never qualifies because wr_en already excludes it.
  assign bypass = RDW_NEW && wr_en && ra_ok && (wa == ra_d);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (ore) begin
      dout     <= bypass ? di : mem_q;
      dout_vld <= ra_ok;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (!POW2 && ((we && !wa_ok && !pwrbus_ram_pd[0]) || (re && !ra_in_ok))) begin
      err <= 1'b1;
    end
  end

endmodule
